// File: rtl/seq_detector_prog.sv
// seq_detector_prog
// Programmable serial sequence detector. Serial bits arriving with valid_in
// are shifted into a history register and compared against a runtime-loadable
// pattern of 1..MAX_LEN bits. A match produces a registered one-cycle pulse on
// detected. In overlapping mode the bits of a match may be reused by the next
// match; in non-overlapping mode a fresh run of len bits is required.
//
// Optional feature macro: SEQ_DET_COUNT_EN
//   defined   -> match_count is a saturating count of matches, cleared on load
//   undefined -> match_count is tied to 0 and no counter flops exist
//
// Ports
//   clk         : single clock, all state updates on its rising edge
//   reset       : asynchronous active-high reset
//   data_in     : serial data bit
//   valid_in    : data_in is sampled only when high
//   load        : one-cycle strobe latching pattern, pat_len and overlap
//   pattern     : new pattern; bit pat_len-1 is received first, bit 0 last
//   pat_len     : new pattern length (0 is taken as 1, >MAX_LEN as MAX_LEN)
//   overlap     : new mode, 1 = overlapping, 0 = non-overlapping
//   detected    : registered one-cycle match pulse
//   match_count : saturating match count (0 when counting is compiled out)

module seq_detector_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1101),
  parameter int                 DEF_LEN     = 4,
  parameter bit                 DEF_OVERLAP = 1'b1,
  localparam int                LEN_W       = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data_in,
  input  logic               valid_in,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count
);

  logic [MAX_LEN-1:0] histQ, histD;
  logic [LEN_W-1:0]   fillQ, fillD;
  logic [MAX_LEN-1:0] patQ, patD;
  logic [LEN_W-1:0]   lenQ, lenD;
  logic               ovlQ, ovlD;
  logic               detQ, detD;

  logic [MAX_LEN-1:0] histShift;
  logic [MAX_LEN-1:0] lenMask;
  logic [LEN_W-1:0]   fillInc;
  logic [LEN_W-1:0]   lenClamp;
  logic               match;

  // Match evaluation works on the post-shift history and post-increment fill,
  // so the bit arriving this cycle is already part of the comparison. The
  // mask keeps only the low len bits; shifting all-ones left by len gives
  // zero when len == MAX_LEN, so the mask saturates to all-ones.
  always_comb begin
    histShift = {histQ[MAX_LEN-2:0], data_in};
    fillInc   = (fillQ == LEN_W'(MAX_LEN)) ? fillQ : fillQ + LEN_W'(1);
    lenMask   = ~({MAX_LEN{1'b1}} << lenQ);
    match     = valid_in && !load &&
                (((histShift ^ patQ) & lenMask) == '0) &&
                (fillInc >= lenQ);

    if (pat_len == '0) begin
      lenClamp = LEN_W'(1);
    end else if (pat_len > LEN_W'(MAX_LEN)) begin
      lenClamp = LEN_W'(MAX_LEN);
    end else begin
      lenClamp = pat_len;
    end
  end

  // Next-state selection. Load wins over a simultaneous sample and discards
  // it. Clearing fill in non-overlapping mode is enough to stop any bit of
  // the matched occurrence from counting again: the stale history bits are
  // masked out by the fill >= len requirement until len new bits arrive.
  always_comb begin
    histD = histQ;
    fillD = fillQ;
    patD  = patQ;
    lenD  = lenQ;
    ovlD  = ovlQ;
    detD  = 1'b0;

    if (load) begin
      patD  = pattern;
      lenD  = lenClamp;
      ovlD  = overlap;
      histD = '0;
      fillD = '0;
    end else if (valid_in) begin
      histD = histShift;
      fillD = (match && !ovlQ) ? '0 : fillInc;
      detD  = match;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      histQ <= '0;
      fillQ <= '0;
      patQ  <= DEF_PATTERN;
      lenQ  <= LEN_W'(DEF_LEN);
      ovlQ  <= DEF_OVERLAP;
      detQ  <= 1'b0;
    end else begin
      histQ <= histD;
      fillQ <= fillD;
      patQ  <= patD;
      lenQ  <= lenD;
      ovlQ  <= ovlD;
      detQ  <= detD;
    end
  end

  assign detected = detQ;

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cntQ, cntD;

  // Saturating match counter; it sticks at all-ones rather than wrapping.
  always_comb begin
    cntD = cntQ;
    if (load) begin
      cntD = '0;
    end else if (match && (cntQ != '1)) begin
      cntD = cntQ + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cntQ <= '0;
    end else begin
      cntQ <= cntD;
    end
  end

  assign match_count = cntQ;
`else
  assign match_count = '0;
`endif

endmodule

// File: doc/seq_detector_prog.md
SEQ_DETECTOR_PROG -- requirements
Module: seq_detector_prog

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, which is the maximum pattern length in bits (2..32).
REQ-002 SHALL have parameter CNT_W, default 8, which is the match counter width.
REQ-003 SHALL have parameter DEF_PATTERN, default 8'b0000_1101, which is the pattern loaded at reset (MAX_LEN bits).
REQ-004 SHALL have parameter DEF_LEN, default 4, which is the pattern length loaded at reset.
REQ-005 SHALL have parameter DEF_OVERLAP, default 1, which is the overlap mode loaded at reset.
REQ-006 SHALL use one clock and an asynchronous, active-high reset, with ports named as in the codebase: clk, reset.
REQ-007 SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-009 SHALL have port data_in, input, 1 bit: the serial data bit.
REQ-010 SHALL have port valid_in, input, 1 bit: data_in is sampled only when this is high.
REQ-011 SHALL have port load, input, 1 bit: a one-cycle strobe that latches pattern, pat_len and overlap.
REQ-012 SHALL have port pattern, input, MAX_LEN bits: the new pattern; bit pat_len-1 is the first bit received and bit 0 is the last.
REQ-013 SHALL have port pat_len, input, $clog2(MAX_LEN)+1 bits: the new pattern length.
REQ-014 SHALL have port overlap, input, 1 bit: the new mode, where 1 means overlapping and 0 means non-overlapping.
REQ-015 SHALL have port detected, output, 1 bit: a registered one-cycle match pulse.
REQ-016 SHALL have port match_count, output, CNT_W bits: a saturating count of matches.

Function
REQ-017 SHALL keep a history shift register hist of MAX_LEN bits; on a valid sample, hist becomes {hist[MAX_LEN-2:0], data_in}.
REQ-018 SHALL keep a fill counter that increments on each valid sample and saturates at MAX_LEN.
REQ-019 SHALL declare a match on a valid sample when the post-shift hist[len-1:0] equals pat[len-1:0] and the post-increment fill is at least len.
REQ-020 SHALL drive detected high for exactly the one cycle following the clock edge that sampled the final pattern bit (latency 1), and low at all other times.
REQ-021 SHALL, on a cycle with valid_in low, hold hist, fill and the other state unchanged and drive detected low on the next cycle.
REQ-022 SHALL, in overlap=1 mode, leave hist and fill unchanged by a match, so that a pattern suffix may start the next match.
REQ-023 SHALL, in overlap=0 mode, clear fill to 0 on a match, so that no bit of a matched occurrence contributes to a later match.
REQ-024 SHALL, when load is high, latch pattern, pat_len and overlap, clear hist and fill, ignore data_in that cycle, and raise no match.
REQ-025 SHALL latch a pat_len of 0 as 1 and a pat_len greater than MAX_LEN as MAX_LEN.
REQ-026 SHALL, when load and valid_in are both high, give load priority and discard the sample.
REQ-027 SHALL increment match_count by 1 on each match, saturating at 2^CNT_W-1 with no wrap.
REQ-028 SHALL clear match_count on load.
REQ-029 SHALL compare only pattern bits below len; bits at len and above are don't-care.

Reset
REQ-030 SHALL, on reset assertion and independent of clk, force detected=0, match_count=0, hist=0 and fill=0.
REQ-031 SHALL, on reset assertion, force pat=DEF_PATTERN, len=DEF_LEN and mode=DEF_OVERLAP.
REQ-032 SHALL abandon any partial match when reset is asserted mid-stream, with the first valid sample after release treated as bit 1 of a fresh stream.

Configuration
REQ-033 SHALL compile match_count logic in only when macro SEQ_DET_COUNT_EN is defined, in which case it behaves per REQ-027 and REQ-028.
REQ-034 SHALL tie match_count to constant 0 when SEQ_DET_COUNT_EN is undefined, with no counter flops; all other behaviour is identical.

Verification
REQ-035 SHALL cover this overlap scenario: with reset defaults (1101, len 4, overlap), a valid stream 1,1,0,1,1,0,1 -> detected pulses after the 4th and 7th bits, and match_count=2.
REQ-036 SHALL cover this non-overlap scenario: load 1101, len 4, overlap=0, then the same stream -> detected pulses only after the 4th bit, and match_count=1.
REQ-037 SHALL cover gapped input: stream 1,1,0,1 with valid_in low for 3 cycles between each bit -> a single detected pulse 1 cycle after the 4th valid bit, with detected low during the gaps.
REQ-038 SHALL cover reset mid-stream: bits 1,1,0, then reset, then bit 1 -> no pulse; the stream 1,1,0,1 that follows -> a pulse.
REQ-039 SHALL cover length clamping: load pat_len=0 with pattern bit0=1, then stream 0,1,1 -> pulses after bits 2 and 3.
REQ-040 SHALL cover counter saturation: CNT_W=2, overlap, len 1 pattern 1, stream of five 1s -> match_count runs 1,2,3,3,3, with detected high throughout.
